// File: rtl/coshx_pkg.sv
// coshx_pkg: shared definitions for the cosh(x) series engine.
//   state_t : controller state encoding (3 bits, exported on the ps port)
//   COEF    : per-step coefficient ROM, COEF[k-1] = floor(65536 / ((2k-1)*2k))
package coshx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_INIT  = 3'd2,
        ST_MUL_C = 3'd3,
        ST_ACC   = 3'd4,
        ST_MUL_X = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Element 0 is the rightmost entry, so COEF[0] = 16'h8000 (1/2).
    localparam logic [7:0][15:0] COEF = {
        16'h0111, 16'h0168, 16'h01F0, 16'h02D8,
        16'h0492, 16'h0888, 16'h1555, 16'h8000
    };

endpackage

// File: rtl/coshx_datapath.sv
// coshx_datapath: registers and arithmetic for the cosh(x) series.
//   clk, rst    : clock, synchronous active-high reset
//   x           : Q0.16 operand, squared into x2/t while zc is high
//   zc          : clear strobe (load acc=1.0, count=0, x2=t=x*x)
//   enc         : accumulate strobe (acc += t, count++)
//   s_mux       : B-mux select, 1 = coefficient ROM, 0 = x2
//   ld_t        : load t with the truncated product t*B
//   result      : accumulator, Q2.16
//   adder       : acc + t (combinational)
//   count       : term counter k-1
//   sel_output  : B-mux output
//   c_out       : terminal count (count==7 while enc)
module coshx_datapath
    import coshx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic        zc,
    input  logic        enc,
    input  logic        s_mux,
    input  logic        ld_t,
    output logic [17:0] result,
    output logic [17:0] adder,
    output logic [2:0]  count,
    output logic [15:0] sel_output,
    output logic        c_out
);

    logic [15:0] x2_q, x2_d;
    logic [15:0] t_q, t_d;
    logic [17:0] acc_q, acc_d;
    logic [2:0]  count_q, count_d;

    logic [15:0] mul_a, mul_b, mul_hi;

    always_comb begin
        sel_output = s_mux ? COEF[count_q] : x2_q;
        // The single multiplier squares x during INIT, otherwise scales t.
        mul_a  = zc ? x : t_q;
        mul_b  = zc ? x : sel_output;
        mul_hi = 16'(({16'h0000, mul_a} * {16'h0000, mul_b}) >> 16);
        adder  = acc_q + {2'b00, t_q};
        c_out  = enc && (count_q == 3'd7);

        x2_d    = x2_q;
        t_d     = t_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (zc) begin
            count_d = '0;
            acc_d   = 18'h10000;
            x2_d    = mul_hi;
            t_d     = mul_hi;
        end else begin
            if (ld_t) begin
                t_d = mul_hi;
            end
            if (enc) begin
                acc_d   = adder;
                count_d = count_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x2_q    <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            x2_q    <= x2_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign result = acc_q;
    assign count  = count_q;

endmodule

// File: rtl/coshx_unit.sv
// coshx_unit: sequential cosh(x) = 1 + sum x^(2k)/(2k)!, k=1..8.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request; computation begins once it is released
//   x          : Q0.16 operand (sampled in INIT)
//   done       : one-cycle completion pulse
//   result     : Q2.16 cosh(x)
//   adder, count, sel_output, c_out : datapath debug taps
//   ps, zc, enc, s_mux              : controller debug taps
module coshx_unit
    import coshx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    output logic        done,
    output logic [17:0] result,
    output logic [17:0] adder,
    output logic [2:0]  count,
    output logic [15:0] sel_output,
    output logic [2:0]  ps,
    output logic        c_out,
    output logic        zc,
    output logic        enc,
    output logic        s_mux
);

    state_t ps_q, ps_d;
    logic   zc_q, zc_d;
    logic   enc_q, enc_d;
    logic   smux_q, smux_d;
    logic   ldt_q, ldt_d;
    logic   done_q, done_d;

    // Strobes are decoded from the next state and registered, so they are
    // glitch-free and line up exactly with the state they belong to.
    always_comb begin
        ps_d = ps_q;
        case (ps_q)
            ST_IDLE:  if (start)  ps_d = ST_WAIT;
            ST_WAIT:  if (!start) ps_d = ST_INIT;
            ST_INIT:  ps_d = ST_MUL_C;
            ST_MUL_C: ps_d = ST_ACC;
            ST_ACC:   ps_d = c_out ? ST_DONE : ST_MUL_X;
            ST_MUL_X: ps_d = ST_MUL_C;
            ST_DONE:  ps_d = ST_IDLE;
            default:  ps_d = ST_IDLE;
        endcase
        zc_d   = (ps_d == ST_INIT);
        enc_d  = (ps_d == ST_ACC);
        smux_d = (ps_d == ST_MUL_C);
        ldt_d  = (ps_d == ST_MUL_C) || (ps_d == ST_MUL_X);
        done_d = (ps_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q   <= ST_IDLE;
            zc_q   <= 1'b0;
            enc_q  <= 1'b0;
            smux_q <= 1'b0;
            ldt_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            zc_q   <= zc_d;
            enc_q  <= enc_d;
            smux_q <= smux_d;
            ldt_q  <= ldt_d;
            done_q <= done_d;
        end
    end

    coshx_datapath u_datapath (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .zc         (zc_q),
        .enc        (enc_q),
        .s_mux      (smux_q),
        .ld_t       (ldt_q),
        .result     (result),
        .adder      (adder),
        .count      (count),
        .sel_output (sel_output),
        .c_out      (c_out)
    );

    assign ps    = ps_q;
    assign zc    = zc_q;
    assign enc   = enc_q;
    assign s_mux = smux_q;
    assign done  = done_q;

endmodule

// File: tb/tb_coshx_unit.sv
module tb_coshx_unit;
    import coshx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic        done;
    logic [17:0] result;
    logic [17:0] adder;
    logic [2:0]  count;
    logic [15:0] sel_output;
    logic [2:0]  ps;
    logic        c_out;
    logic        zc;
    logic        enc;
    logic        s_mux;

    coshx_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x          (x),
        .done       (done),
        .result     (result),
        .adder      (adder),
        .count      (count),
        .sel_output (sel_output),
        .ps         (ps),
        .c_out      (c_out),
        .zc         (zc),
        .enc        (enc),
        .s_mux      (s_mux)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] xv;
        int          hold;
        logic [17:0] exp;
        int          tol;
        bit          zero_case;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic [17:0] act, input logic [17:0] exp,
                           input int tol);
        int d;
        n_checks++;
        d = int'(act) - int'(exp);
        if (d < 0) d = -d;
        if ($isunknown(act) || d > tol) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h +/- %0d", name, act, exp, tol);
        end
    endtask

    // Run one computation; inputs change and outputs are sampled on negedges.
    task automatic run_op(input logic [15:0] xv, input int hold, output logic [17:0] res,
                          output int lat, output int dcnt, output int wait_err,
                          output int strobe_err, output int adder_err, output bit timed_out);
        bit seen_init;
        bit finished;
        lat = 0; dcnt = 0; wait_err = 0; strobe_err = 0; adder_err = 0;
        seen_init = 1'b0; finished = 1'b0; timed_out = 1'b0;
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ps !== 3'(ST_WAIT)) wait_err++;
        end
        start = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            @(negedge clk);
            if (ps == 3'(ST_INIT)) seen_init = 1'b1;
            if (seen_init) lat++;
            if (done) dcnt++;
            if (zc !== (ps == 3'(ST_INIT)) || enc !== (ps == 3'(ST_ACC)) ||
                s_mux !== (ps == 3'(ST_MUL_C)))
                strobe_err++;
            if (enc && adder !== result) adder_err++;
            if (ps == 3'(ST_DONE)) finished = 1'b1;
        end
        if (!finished) begin
            timed_out = 1'b1;
            $display("FAIL run_timeout: x=%h never reached DONE", xv);
        end
        res = result;
        // One more cycle: done must already be low, FSM back in IDLE.
        @(negedge clk);
        if (done) dcnt++;
        if (ps !== 3'(ST_IDLE)) wait_err++;
    endtask

    logic [17:0] res, res_first;
    int          lat, dcnt, wait_err, strobe_err, adder_err;
    bit          to;

    initial begin
        vecs[0] = '{16'h8000,  2, 18'h120AC, 8, 1'b0};
        vecs[1] = '{16'hCCCC,  1, 18'h15662, 8, 1'b0};
        vecs[2] = '{16'h0000,  1, 18'h10000, 0, 1'b1};
        vecs[3] = '{16'hFFFF,  1, 18'h18B07, 8, 1'b0};
        vecs[4] = '{16'hCCCC, 10, 18'h15662, 8, 1'b0};

        rst = 1'b1; start = 1'b0; x = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ps",     32'(ps),     32'(ST_IDLE));
        chk("reset_result", 32'(result), 32'h0);
        chk("reset_done",   32'(done),   32'h0);
        chk("reset_count",  32'(count),  32'h0);
        chk("reset_strobe", {29'b0, zc, enc, s_mux}, 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_op(vecs[v].xv, vecs[v].hold, res, lat, dcnt, wait_err, strobe_err, adder_err, to);
            chk("run_timeout", 32'(to), 32'h0);
            chk_tol($sformatf("result_x%h", vecs[v].xv), res, vecs[v].exp, vecs[v].tol);
            chk("latency_init_to_done", 32'(lat), 32'd25);
            chk("done_pulse_cycles", 32'(dcnt), 32'd1);
            chk("wait_and_idle", 32'(wait_err), 32'd0);
            chk("strobe_decode", 32'(strobe_err), 32'd0);
            chk("count_wrapped", 32'(count), 32'h0);
            chk("result_holds", 32'(result), 32'(res));
            if (vecs[v].zero_case) chk("adder_eq_acc_x0", 32'(adder_err), 32'd0);
            if (v == 1) res_first = res;
            if (v == 4) chk("back_to_back_same", 32'(res), 32'(res_first));
        end

        // Reset in the middle of a computation.
        @(negedge clk);
        x = 16'hCCCC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge clk);
                if (ps == 3'(ST_MUL_X)) hit = 1'b1;
            end
            chk("reach_mul_x", 32'(hit), 32'h1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ps",     32'(ps),     32'(ST_IDLE));
        chk("midrst_result", 32'(result), 32'h0);
        chk("midrst_done",   32'(done),   32'h0);
        chk("midrst_count",  32'(count),  32'h0);
        rst = 1'b0;

        run_op(16'h8000, 1, res, lat, dcnt, wait_err, strobe_err, adder_err, to);
        chk("after_rst_timeout", 32'(to), 32'h0);
        chk_tol("after_rst_result", res, 18'h120AC, 8);
        chk("after_rst_latency", 32'(lat), 32'd25);
        chk("after_rst_done", 32'(dcnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
